// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register plus IF/ID pipeline register, honouring stalls and branch redirects.
// Optional `FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_stall,
    input  logic        IF_ID_stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc_plus4,
    output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        take;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    // A stalled branch cannot resolve, so flush only counts when the PC is free to move.
    assign take      = flush & ~pc_stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC & 32'hFFFF_FFFC;
        else if (!pc_stall)
            pc <= flush ? (branch_target & 32'hFFFF_FFFC) : pc_plus4;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_pc_plus4 <= 32'd0;
            IF_ID_valid    <= 1'b0;
        end else if (!IF_ID_stall) begin
            IF_ID_instr    <= take ? NOP_INSTR : imem_rdata;
            IF_ID_pc_plus4 <= take ? 32'd0 : pc_plus4;
            IF_ID_valid    <= ~take;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_cnt + {31'd0, pc_stall && (stall_cnt != 32'hFFFF_FFFF)};
            flush_cnt <= flush_cnt + {31'd0, take && (flush_cnt != 32'hFFFF_FFFF)};
        end
    end
`endif
endmodule
